// File: rtl/ifetch_seq_if.sv
// Instruction-memory read bus: ifetch_seq drives address/read enable (master),
// the synchronous instruction memory returns the word one cycle later (slave).
interface ifetch_seq_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] IM_addr;
    logic              IM_rd;
    logic [13:0]       IM_data;

    modport master (
        output IM_addr,
        output IM_rd,
        input  IM_data
    );

    modport slave (
        input  IM_addr,
        input  IM_rd,
        output IM_data
    );
endinterface

// File: rtl/ifetch_seq.sv
// Fetch/sequencing controller for the 14-bit IW core: PC, return stack, JUMP/CALL/RET/STALL.
// Optional issued-instruction counter enabled by defining INSN_CNT_EN.
module ifetch_seq #(
    parameter int ADDR_W    = 10,
    parameter int STK_DEPTH = 8,
    parameter int DATA_W    = 16
) (
    input  logic              Clk_pin,
    input  logic              Resetn_pin,
    ifetch_seq_if.master      im,
    input  logic [3:0]        Flags,
    output logic [3:0]        Rsel,
    input  logic [DATA_W-1:0] Rdata,
    input  logic              Mdone,
    output logic [13:0]       IR,
    output logic              IR_valid,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted,
    output logic              Err,
    output logic [31:0]       Icount
);

    localparam int IDX_W = $clog2(STK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [5:0]  OP_JUMP  = 6'h04;
    localparam logic [5:0]  OP_MUL   = 6'h10;
    localparam logic [5:0]  OP_DIV   = 6'h11;
    localparam logic [5:0]  OP_CALL  = 6'h1B;
    localparam logic [5:0]  OP_RET   = 6'h1C;
    localparam logic [5:0]  OP_LAST  = 6'h1E;
    localparam logic [13:0] IW_STALL = 14'h3FFF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_JTGT,
        S_WAIT,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [13:0]         r_ir;
    logic [13:0]         w_ir_nxt;
    logic                r_ir_valid;
    logic                w_ir_valid_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [SP_W-1:0]     r_sp;
    logic [SP_W-1:0]     w_sp_dec;
    logic [ADDR_W-1:0]   r_stack [STK_DEPTH];

    logic [5:0]          w_opcode;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_inc2;
    logic [ADDR_W-1:0]   w_stk_top;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_taken;
    logic                w_cond_bad;
    logic [ADDR_W-1:0]   w_im_addr;
    logic                w_im_rd;
    logic                w_unused_rdata;

    assign w_opcode  = im.IM_data[13:8];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_pc_inc2 = r_pc + ADDR_W'(2);
    assign w_sp_dec  = r_sp - SP_W'(1);
    assign w_stk_top = r_stack[w_sp_dec[IDX_W-1:0]];
    assign w_full    = (r_sp == SP_W'(STK_DEPTH));
    assign w_empty   = (r_sp == '0);

    // Only the low ADDR_W bits of a register form a CALL target.
    assign w_unused_rdata = ^Rdata;

    // Jump condition: IR[3:0] one-hot selects a flag, its complement tests the flag clear.
    always_comb begin
        w_taken    = 1'b0;
        w_cond_bad = 1'b0;
        case (r_ir[3:0])
            4'b0000: w_taken = 1'b1;
            4'b1000: w_taken = Flags[3];
            4'b0100: w_taken = Flags[2];
            4'b0010: w_taken = Flags[1];
            4'b0001: w_taken = Flags[0];
            4'b0111: w_taken = ~Flags[3];
            4'b1011: w_taken = ~Flags[2];
            4'b1101: w_taken = ~Flags[1];
            4'b1110: w_taken = ~Flags[0];
            default: w_cond_bad = 1'b1;
        endcase
    end

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_valid_nxt = 1'b0;
        w_err_nxt      = r_err;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_im_addr      = r_pc;
        w_im_rd        = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_im_rd     = 1'b1;
                w_state_nxt = S_DECODE;
            end

            S_DECODE: begin
                w_ir_nxt = im.IM_data;
                if (im.IM_data == IW_STALL) begin
                    w_state_nxt = S_HALT;
                end else if (w_opcode == OP_JUMP) begin
                    w_im_addr   = w_pc_inc;
                    w_im_rd     = 1'b1;
                    w_state_nxt = S_JTGT;
                end else if (w_opcode == OP_CALL) begin
                    w_state_nxt = S_FETCH;
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                        w_pc_nxt  = w_pc_inc;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = Rdata[ADDR_W-1:0];
                    end
                end else if (w_opcode == OP_RET) begin
                    w_state_nxt = S_FETCH;
                    if (w_empty) begin
                        w_err_nxt = 1'b1;
                        w_pc_nxt  = w_pc_inc;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_stk_top;
                    end
                end else if (w_opcode <= OP_LAST) begin
                    w_ir_valid_nxt = 1'b1;
                    w_pc_nxt       = w_pc_inc;
                    w_state_nxt    = ((w_opcode == OP_MUL) || (w_opcode == OP_DIV)) ? S_WAIT : S_FETCH;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end

            S_JTGT: begin
                w_state_nxt = S_FETCH;
                if (w_cond_bad) begin
                    w_err_nxt = 1'b1;
                end
                w_pc_nxt = w_taken ? im.IM_data[ADDR_W-1:0] : w_pc_inc2;
            end

            S_WAIT: begin
                if (Mdone) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_ir       <= 14'h0000;
            r_ir_valid <= 1'b0;
            r_err      <= 1'b0;
            r_sp       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_err      <= w_err_nxt;
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= w_sp_dec;
            end
        end
    end

    // NOTE: return-stack storage is not reset; the pointer alone decides which entries are live.
    always_ff @(posedge Clk_pin) begin
        if (w_push) begin
            r_stack[r_sp[IDX_W-1:0]] <= w_pc_inc;
        end
    end

`ifdef INSN_CNT_EN
    logic [31:0] r_icount;
    logic        w_cnt_evt;

    // IR_valid cycles plus one count per JUMP (resolved in S_JTGT) and per CALL/RET.
    assign w_cnt_evt = r_ir_valid
                     | (r_state == S_JTGT)
                     | ((r_state == S_DECODE) && ((w_opcode == OP_CALL) || (w_opcode == OP_RET)));

    always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_icount <= '0;
        end else if (w_cnt_evt && (r_icount != 32'hFFFF_FFFF)) begin
            r_icount <= r_icount + 32'd1;
        end
    end

    assign Icount = r_icount;
`else
    assign Icount = 32'h0;
`endif

    // Read enable is held low while reset is asserted even though the reset state is S_FETCH.
    assign im.IM_rd   = w_im_rd & Resetn_pin;
    assign im.IM_addr = w_im_addr;

    assign Rsel     = (r_state == S_DECODE) ? im.IM_data[7:4] : r_ir[7:4];
    assign IR       = r_ir;
    assign IR_valid = r_ir_valid;
    assign PC       = r_pc;
    assign Halted   = (r_state == S_HALT);
    assign Err      = r_err;

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: synchronous IM model, register-file model, fetch-address log.
module tb_ifetch_seq;

`ifdef INSN_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  flags;
    logic [3:0]  rsel;
    logic [15:0] rdata;
    logic        mdone;
    logic [13:0] ir;
    logic        ir_valid;
    logic [9:0]  pc;
    logic        halted;
    logic        err;
    logic [31:0] icount;

    logic [13:0] mem  [1024];
    logic [15:0] regs [16];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int base  = 0;
    int fetch_q[$];
    int fetch_cyc[$];
    int irv_q[$];
    int irv_cyc[$];
    int exp_q[$];

    always #5 clk = ~clk;

    ifetch_seq_if #(.ADDR_W(10)) bus ();

    ifetch_seq #(.ADDR_W(10), .STK_DEPTH(8), .DATA_W(16)) dut (
        .Clk_pin    (clk),
        .Resetn_pin (rst_n),
        .im         (bus),
        .Flags      (flags),
        .Rsel       (rsel),
        .Rdata      (rdata),
        .Mdone      (mdone),
        .IR         (ir),
        .IR_valid   (ir_valid),
        .PC         (pc),
        .Halted     (halted),
        .Err        (err),
        .Icount     (icount)
    );

    assign rdata = regs[rsel];

    always @(posedge clk) begin
        if (bus.IM_rd) bus.IM_data <= mem[bus.IM_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.IM_rd) begin
                fetch_q.push_back(int'(bus.IM_addr));
                fetch_cyc.push_back(cyc - base);
            end
            if (ir_valid) begin
                irv_q.push_back(int'(ir));
                irv_cyc.push_back(cyc - base);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int n);
        return CNT_ON ? 32'(n) : 32'h0;
    endfunction

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 14'h3FFF;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    endtask

    task automatic do_reset(input bit chk, input string tag);
        rst_n = 1'b0;
        run(2);
        if (chk) begin
            check({tag, "_pc"}, 32'(pc), 32'h0);
            check({tag, "_ir"}, 32'(ir), 32'h0);
            check({tag, "_irv"}, 32'(ir_valid), 32'h0);
            check({tag, "_imrd"}, 32'(bus.IM_rd), 32'h0);
            check({tag, "_halt"}, 32'(halted), 32'h0);
            check({tag, "_err"}, 32'(err), 32'h0);
            check({tag, "_icnt"}, icount, 32'h0);
        end
        fetch_q.delete();
        fetch_cyc.delete();
        irv_q.delete();
        irv_cyc.delete();
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic check_fetches(input string tag);
        int n;
        check({tag, "_nfetch"}, 32'(fetch_q.size()), 32'(exp_q.size()));
        n = (fetch_q.size() < exp_q.size()) ? fetch_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_fetch%0d", tag, i), 32'(fetch_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst_n = 1'b0;
        mdone = 1'b0;
        flags = 4'h0;

        // ADD, SUB, STALL
        clear_mem();
        mem[0] = 14'h0512;
        mem[1] = 14'h0623;
        do_reset(1'b1, "rst");
        run(12);
        check("seq_nirv", 32'(irv_q.size()), 32'd2);
        if (irv_q.size() == 2) begin
            check("seq_ir0", 32'(irv_q[0]), 32'h0512);
            check("seq_ir1", 32'(irv_q[1]), 32'h0623);
            check("seq_cyc0", 32'(irv_cyc[0]), 32'd2);
            check("seq_gap", 32'(irv_cyc[1] - irv_cyc[0]), 32'd2);
        end
        check("seq_halt", 32'(halted), 32'h1);
        check("seq_pc", 32'(pc), 32'h2);
        check("seq_imrd", 32'(bus.IM_rd), 32'h0);
        check("seq_err", 32'(err), 32'h0);
        check("seq_icnt", icount, cexp(2));
        exp_q = '{0, 1, 2};
        check_fetches("seq");

        // JUMP Z=1 at PC=4 -> 0x020
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 14'h0000;
        mem[4] = 14'h0401;
        mem[5] = 14'h0020;
        flags  = 4'b0001;
        do_reset(1'b0, "");
        run(30);
        exp_q = '{0, 1, 2, 3, 4, 5, 32};
        check_fetches("jz1");
        check("jz1_pc", 32'(pc), 32'h20);
        check("jz1_err", 32'(err), 32'h0);
        check("jz1_icnt", icount, cexp(5));

        // same JUMP with Z=0 -> falls through to 6
        flags = 4'b0000;
        do_reset(1'b0, "");
        run(30);
        exp_q = '{0, 1, 2, 3, 4, 5, 6};
        check_fetches("jz0");
        check("jz0_pc", 32'(pc), 32'h6);
        check("jz0_err", 32'(err), 32'h0);

        // target word wider than ADDR_W wraps: 0x420 -> 0x020
        mem[5] = 14'h0420;
        flags  = 4'b0001;
        do_reset(1'b0, "");
        run(30);
        exp_q = '{0, 1, 2, 3, 4, 5, 32};
        check_fetches("jwrap");

        // bad condition code 0x3 -> not taken, Err
        mem[4] = 14'h0403;
        mem[5] = 14'h0020;
        do_reset(1'b0, "");
        run(30);
        exp_q = '{0, 1, 2, 3, 4, 5, 6};
        check_fetches("jbad");
        check("jbad_err", 32'(err), 32'h1);
        check("jbad_pc", 32'(pc), 32'h6);

        // JUMP to 0x10, CALL R3 -> 0x100, RET -> 0x11
        clear_mem();
        mem[0]     = 14'h0400;
        mem[1]     = 14'h0010;
        mem[16]    = 14'h1B30;
        mem[256]   = 14'h1C00;
        regs[3]    = 16'h0100;
        flags      = 4'b0000;
        do_reset(1'b0, "");
        run(30);
        exp_q = '{0, 1, 16, 256, 17};
        check_fetches("call");
        check("call_pc", 32'(pc), 32'h11);
        check("call_err", 32'(err), 32'h0);
        check("call_icnt", icount, cexp(3));

        // nine nested CALLs: the ninth overflows and falls through
        clear_mem();
        for (int i = 1; i <= 9; i++) begin
            regs[i]          = 16'(i * 16);
            mem[(i - 1) * 16] = 14'h1B00 | 14'(i << 4);
        end
        do_reset(1'b0, "");
        run(40);
        exp_q = '{0, 16, 32, 48, 64, 80, 96, 112, 128, 129};
        check_fetches("nest");
        check("nest_err", 32'(err), 32'h1);
        check("nest_pc", 32'(pc), 32'h81);
        check("nest_icnt", icount, cexp(9));

        // RET on empty stack at PC=7
        clear_mem();
        for (int i = 0; i < 7; i++) mem[i] = 14'h0000;
        mem[7] = 14'h1C00;
        do_reset(1'b0, "");
        run(30);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        check_fetches("ret0");
        check("ret0_err", 32'(err), 32'h1);
        check("ret0_pc", 32'(pc), 32'h8);
        check("ret0_icnt", icount, cexp(8));

        // MUL: single IR_valid, no fetch until Mdone 5 cycles later
        clear_mem();
        mem[0] = 14'h1012;
        do_reset(1'b0, "");
        run(2);
        check("mul_irv", 32'(ir_valid), 32'h1);
        check("mul_ir", 32'(ir), 32'h1012);
        run(5);
        check("mul_hold_nfetch", 32'(fetch_q.size()), 32'd1);
        check("mul_hold_imrd", 32'(bus.IM_rd), 32'h0);
        mdone = 1'b1;
        run(1);
        mdone = 1'b0;
        check("mul_rel_imrd", 32'(bus.IM_rd), 32'h1);
        check("mul_rel_addr", 32'(bus.IM_addr), 32'h1);
        run(10);
        exp_q = '{0, 1};
        check_fetches("mul");
        if (fetch_cyc.size() > 1) check("mul_fcyc", 32'(fetch_cyc[1]), 32'd8);
        check("mul_nirv", 32'(irv_q.size()), 32'd1);
        check("mul_pc", 32'(pc), 32'h1);

        // DIV with Mdone coincident with IR_valid: exactly one cycle in S_WAIT
        mem[0] = 14'h1100;
        do_reset(1'b0, "");
        run(2);
        mdone = 1'b1;
        run(1);
        mdone = 1'b0;
        run(10);
        exp_q = '{0, 1};
        check_fetches("div");
        if (fetch_cyc.size() > 1) check("div_fcyc", 32'(fetch_cyc[1]), 32'd3);

        // ordinary instruction at 0x3FF wraps to 0
        clear_mem();
        mem[0]    = 14'h0401;
        mem[1]    = 14'h03FF;
        mem[1023] = 14'h0000;
        flags     = 4'b0001;
        do_reset(1'b0, "");
        run(5);
        flags = 4'b0000;
        run(20);
        exp_q = '{0, 1, 1023, 0, 1, 2};
        check_fetches("wrap");
        check("wrap_pc", 32'(pc), 32'h2);
        check("wrap_err", 32'(err), 32'h0);
        check("wrap_icnt", icount, cexp(3));

        // undefined opcode then MUL; reset while waiting with Mdone pending
        clear_mem();
        mem[0] = 14'h2000;
        mem[1] = 14'h1012;
        do_reset(1'b0, "");
        run(5);
        check("wait_err", 32'(err), 32'h1);
        check("wait_pc", 32'(pc), 32'h2);
        check("wait_imrd", 32'(bus.IM_rd), 32'h0);
        check("wait_icnt", icount, cexp(1));
        mdone = 1'b1;
        do_reset(1'b1, "rst_wait");
        run(1);
        mdone = 1'b0;
        run(1);
        exp_q = '{0};
        check_fetches("after_rst");
        check("after_rst_err", 32'(err), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
